serv_exec_seq: RTL
==================

SERV_EXEC_SEQ -- requirements
Module: serv_exec_seq

Interface
REQ-001 SHALL have parameter MDU, default 0: when 1, i_mdu_op/i_mdu_ready are honoured; when 0, both are ignored.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port o_ibus_cyc, output, 1, instruction fetch request.
REQ-005 SHALL have port i_ibus_ack, input, 1, instruction fetch acknowledge.
REQ-006 SHALL have port o_wb_en, output, 1, decoder load strobe.
REQ-007 SHALL have port i_two_stage_op, input, 1, decoded two-stage flag.
REQ-008 SHALL have port i_dbus_en, input, 1, decoded data-bus op flag.
REQ-009 SHALL have port i_mdu_op, input, 1, decoded MDU op flag.
REQ-010 SHALL have port o_dbus_cyc, output, 1, data bus request.
REQ-011 SHALL have port i_dbus_ack, input, 1, data bus acknowledge.
REQ-012 SHALL have port i_mdu_ready, input, 1, MDU result ready.
REQ-013 SHALL have port o_rf_rreq, output, 1, register file read request pulse.
REQ-014 SHALL have port i_rf_ready, input, 1, register file operands available.
REQ-015 SHALL have port o_init, output, 1, first-stage pass active.
REQ-016 SHALL have port o_cnt_en, output, 1, serial bit counter running.
REQ-017 SHALL have port o_cnt, output, 5, current serial bit index.
REQ-018 SHALL have port o_cnt_done, output, 1, last bit of a pass (o_cnt_en & o_cnt==31).
REQ-019 SHALL have port o_pc_en, output, 1, PC update strobe.

Function
REQ-020 SHALL implement a Moore FSM with states FETCH, DECODE, RFWAIT, INIT, BUSWAIT, RUN; all outputs except o_wb_en and o_cnt_done SHALL be decoded from registered state/counter only.
REQ-021 FETCH: o_ibus_cyc=1; on i_ibus_ack go to DECODE; o_wb_en = FETCH & i_ibus_ack (same cycle as ack).
REQ-022 DECODE: exactly one cycle; o_rf_rreq=1; then RFWAIT.
REQ-023 RFWAIT: hold until i_rf_ready=1, then go to INIT if i_two_stage_op else RUN; RFWAIT lasts at least one cycle.
REQ-024 INIT: o_init=1, o_cnt_en=1 for 32 cycles; on o_cnt_done go to BUSWAIT.
REQ-025 BUSWAIT: o_dbus_cyc = i_dbus_en; exit to RUN on i_dbus_ack if i_dbus_en, else on i_mdu_ready if MDU & i_mdu_op, else after exactly one cycle.
REQ-026 RUN: o_cnt_en=1 for 32 cycles; on o_cnt_done assert o_pc_en for that cycle and go to FETCH.
REQ-027 o_cnt SHALL increment modulo 32 only while o_cnt_en=1, wrapping 31->0 at each pass end; it is 0 on every entry to INIT and RUN.
REQ-028 i_ibus_ack outside FETCH and i_dbus_ack outside BUSWAIT SHALL be ignored.
REQ-029 Decoded inputs (i_two_stage_op, i_dbus_en, i_mdu_op) SHALL be treated as stable from DECODE until the next FETCH.
REQ-030 Single-stage latency: ack at cycle N, RUN occupies N+3..N+34 with i_rf_ready already high, and FETCH resumes at N+35.

Reset
REQ-031 On i_rst=1, the block SHALL immediately enter FETCH with o_cnt=0 and drive o_ibus_cyc=1 after release; all other outputs SHALL be 0.
REQ-032 Reset asserted mid-pass or mid-bus-cycle SHALL abort the operation with no o_pc_en pulse and drop o_dbus_cyc asynchronously.

Verification
REQ-033 Release reset with ack at cycle 2 and rf_ready high: require o_wb_en at cycle 2, o_rf_rreq at cycle 3, and o_cnt 0..31 at cycles 5..36, with o_pc_en at 36 and o_ibus_cyc at 37.
REQ-034 Load (two_stage=1, dbus_en=1) with dbus_ack delayed 7 cycles: require o_init for 32 cycles, o_dbus_cyc high for 8 cycles, then a 32-cycle RUN.
REQ-035 With MDU=1, two_stage=1, mdu_op=1, mdu_ready after 40 cycles: require BUSWAIT for 40 cycles, o_dbus_cyc=0, then RUN; with MDU=0 the same stimulus requires a 1-cycle BUSWAIT.
REQ-036 Shift op (two_stage=1, dbus_en=0): require BUSWAIT of exactly 1 cycle between passes; a spurious dbus_ack during RUN has no effect.
REQ-037 Assert i_rst at o_cnt=17 of RUN: require o_cnt=0 and o_cnt_en=0 immediately, no o_pc_en pulse, and o_ibus_cyc=1 on the first cycle after release.

Source files
------------

// File: rtl/serv_exec_seq.sv
// -----------------------------------------------------------------------------
// serv_exec_seq
//   Execution sequencer for a bit-serial RISC-V core. Walks each instruction
//   through fetch, decode, register-file wait, an optional first serial pass
//   (INIT), an optional bus/MDU wait, and the main 32-cycle serial pass (RUN).
//
// Parameters
//   MDU            : 1 honours i_mdu_op / i_mdu_ready, 0 ignores them
//
// Ports
//   clk            : sole clock, rising edge
//   i_rst          : asynchronous active-high reset
//   o_ibus_cyc     : instruction fetch request (FETCH)
//   i_ibus_ack     : instruction fetch acknowledge
//   o_wb_en        : decoder load strobe (FETCH & i_ibus_ack)
//   i_two_stage_op : decoded two-stage flag
//   i_dbus_en      : decoded data-bus op flag
//   i_mdu_op       : decoded MDU op flag
//   o_dbus_cyc     : data bus request (BUSWAIT of a data-bus op)
//   i_dbus_ack     : data bus acknowledge
//   i_mdu_ready    : MDU result ready
//   o_rf_rreq      : register file read request pulse (DECODE)
//   i_rf_ready     : register file operands available
//   o_init         : first-stage pass active
//   o_cnt_en       : serial bit counter running
//   o_cnt          : current serial bit index
//   o_cnt_done     : last bit of a pass
//   o_pc_en        : PC update strobe (last bit of RUN)
// -----------------------------------------------------------------------------
module serv_exec_seq #(
    parameter int MDU = 0
) (
    input  logic       clk,
    input  logic       i_rst,
    output logic       o_ibus_cyc,
    input  logic       i_ibus_ack,
    output logic       o_wb_en,
    input  logic       i_two_stage_op,
    input  logic       i_dbus_en,
    input  logic       i_mdu_op,
    output logic       o_dbus_cyc,
    input  logic       i_dbus_ack,
    input  logic       i_mdu_ready,
    output logic       o_rf_rreq,
    input  logic       i_rf_ready,
    output logic       o_init,
    output logic       o_cnt_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt_done,
    output logic       o_pc_en
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_RFWAIT  = 3'd2,
        S_INIT    = 3'd3,
        S_BUSWAIT = 3'd4,
        S_RUN     = 3'd5
    } state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    // Decoded flags are captured in DECODE so every output stays a pure
    // function of registered state, even if the decoder outputs wiggle later.
    logic       r_two_stage;
    logic       r_dbus_en;
    logic       r_mdu_op;

    logic       w_cnt_en;
    logic       w_last_bit;
    logic       w_mdu_wait;

    assign w_cnt_en   = (r_state == S_INIT) || (r_state == S_RUN);
    assign w_last_bit = (r_cnt == 5'd31);
    // With MDU disabled the MDU flag is forced low, so BUSWAIT falls through.
    assign w_mdu_wait = (MDU != 0) ? r_mdu_op : 1'b0;

    assign o_ibus_cyc = (r_state == S_FETCH);
    assign o_wb_en    = (r_state == S_FETCH) && i_ibus_ack;
    assign o_rf_rreq  = (r_state == S_DECODE);
    assign o_init     = (r_state == S_INIT);
    assign o_cnt_en   = w_cnt_en;
    assign o_cnt      = r_cnt;
    assign o_cnt_done = w_cnt_en && w_last_bit;
    assign o_pc_en    = (r_state == S_RUN) && w_last_bit;
    assign o_dbus_cyc = (r_state == S_BUSWAIT) && r_dbus_en;

    // Sequencer state, serial bit counter and captured decode flags.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_FETCH;
            r_cnt       <= 5'd0;
            r_two_stage <= 1'b0;
            r_dbus_en   <= 1'b0;
            r_mdu_op    <= 1'b0;
        end else begin
            // Counter wraps 31->0 at the end of every pass, so it is already
            // zero whenever INIT or RUN is entered.
            if (w_cnt_en) begin
                r_cnt <= r_cnt + 5'd1;
            end else begin
                r_cnt <= r_cnt;
            end

            case (r_state)
                S_FETCH: begin
                    if (i_ibus_ack) begin
                        r_state <= S_DECODE;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    r_two_stage <= i_two_stage_op;
                    r_dbus_en   <= i_dbus_en;
                    r_mdu_op    <= i_mdu_op;
                    r_state     <= S_RFWAIT;
                end
                S_RFWAIT: begin
                    if (i_rf_ready) begin
                        r_state <= r_two_stage ? S_INIT : S_RUN;
                    end else begin
                        r_state <= S_RFWAIT;
                    end
                end
                S_INIT: begin
                    if (w_last_bit) begin
                        r_state <= S_BUSWAIT;
                    end else begin
                        r_state <= S_INIT;
                    end
                end
                S_BUSWAIT: begin
                    // Data-bus ops wait for ack, MDU ops for ready, anything
                    // else (shifts, SLT...) spends exactly one cycle here.
                    if (r_dbus_en) begin
                        r_state <= i_dbus_ack ? S_RUN : S_BUSWAIT;
                    end else if (w_mdu_wait) begin
                        r_state <= i_mdu_ready ? S_RUN : S_BUSWAIT;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last_bit) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule
